// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl -- HI/LO multiply unit controller.
//
// Multicycle radix-2 shift-add multiplier that owns the architectural HI/LO
// registers. A multiply is accepted in IDLE and runs 32 ITER cycles on the
// operand magnitudes. One FIX cycle applies the product sign. One WRITE
// cycle then commits to {Hi,Lo} (MULT/MULTU/MADD/MSUB) or to Result (MUL).
// MTHI/MTLO write Hi/Lo directly at the accept edge and never go busy.
//
// Ports:
//   Clk      rising-edge clock
//   Rst_n    asynchronous active-low reset
//   Start    issue request for Op/A/B (taken only in IDLE)
//   Op       3-bit opcode (MULT, MULTU, MADD, MSUB, MTHI, MTLO, MUL, reserved)
//   A, B     operands rs / rt
//   Flush    synchronous abandon of any in-flight operation
//   ReadReq  pipeline is reading HI/LO this cycle
//   Busy     state is not IDLE
//   Stall    (ReadReq | Start) & Busy
//   Done     one-cycle pulse after a multicycle operation commits
//   Result   low word of the last completed MUL
//   Hi, Lo   architectural HI / LO registers
module hilo_mdu_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [2:0]        Op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Flush,
    input  logic              ReadReq,
    output logic              Busy,
    output logic              Stall,
    output logic              Done,
    output logic [DATA_W-1:0] Result,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo
);

    localparam int W2    = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ITER  = 2'd1,
        S_FIX   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic               sign_q;
    logic [DATA_W-1:0]  mcand;
    logic [DATA_W-1:0]  mplier;
    logic [W2-1:0]      prod;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W:0]    step_sum;
    logic               is_mult_op;
    logic               is_signed_op;

    // Magnitude of a two's-complement operand; unsigned ops pass through.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic is_signed);
        if (is_signed && v[DATA_W-1])
            return ~v + DATA_W'(1);
        else
            return v;
    endfunction

    function automatic logic [W2-1:0] negate(input logic [W2-1:0] v);
        return ~v + W2'(1);
    endfunction

    assign Busy  = (state != S_IDLE);
    assign Stall = (ReadReq | Start) & Busy;

    assign is_mult_op   = (Op == OP_MULT) || (Op == OP_MULTU) || (Op == OP_MADD) ||
                          (Op == OP_MSUB) || (Op == OP_MUL);
    assign is_signed_op = (Op != OP_MULTU);

    // The multiplier shifts out LSB-first while partial sums shift into the
    // low half of prod, so after DATA_W steps prod holds mcand * mplier.
    assign step_sum = {1'b0, prod[W2-1:DATA_W]} + {1'b0, (mplier[0] ? mcand : '0)};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            sign_q <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            Hi     <= '0;
            Lo     <= '0;
            Result <= '0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Flush) begin
                // Flush wins over everything, including an MTHI/MTLO in IDLE.
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (Start) begin
                            if (is_mult_op) begin
                                op_q   <= Op;
                                sign_q <= is_signed_op & (A[DATA_W-1] ^ B[DATA_W-1]);
                                mcand  <= magnitude(A, is_signed_op);
                                mplier <= magnitude(B, is_signed_op);
                                prod   <= '0;
                                cnt    <= '0;
                                state  <= S_ITER;
                            end else if (Op == OP_MTHI) begin
                                Hi <= A;
                            end else if (Op == OP_MTLO) begin
                                Lo <= A;
                            end
                        end
                    end
                    S_ITER: begin
                        prod   <= {step_sum, prod[DATA_W-1:1]};
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_W - 1))
                            state <= S_FIX;
                    end
                    S_FIX: begin
                        if (sign_q)
                            prod <= negate(prod);
                        state <= S_WRITE;
                    end
                    S_WRITE: begin
                        case (op_q)
                            OP_MULT, OP_MULTU: {Hi, Lo} <= prod;
                            OP_MADD:           {Hi, Lo} <= {Hi, Lo} + prod;
                            OP_MSUB:           {Hi, Lo} <= {Hi, Lo} - prod;
                            OP_MUL:            Result   <= prod[DATA_W-1:0];
                            default:           ;
                        endcase
                        Done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Testbench for hilo_mdu_ctrl: directed corner cases plus randomized ops,
// expected HI/LO/Result taken from a plain-arithmetic architectural model.
module tb_hilo_mdu_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        ReadReq;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] Result;
    logic [31:0] Hi;
    logic [31:0] Lo;

    hilo_mdu_ctrl #(.DATA_W(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .ReadReq(ReadReq), .Busy(Busy), .Stall(Stall),
        .Done(Done), .Result(Result), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Architectural model state
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_res = '0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Apply one op to the model; returns 1 when the op completes with a Done pulse.
    function automatic bit model_apply(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        logic [63:0] hl;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(a) * 64'(b);
        hl = {m_hi, m_lo};
        case (op)
            3'd0: hl = sp;
            3'd1: hl = up;
            3'd2: hl = hl + sp;
            3'd3: hl = hl - sp;
            3'd4: hl[63:32] = a;
            3'd5: hl[31:0] = a;
            3'd6: m_res = sp[31:0];
            default: ;
        endcase
        m_hi = hl[63:32];
        m_lo = hl[31:0];
        return (op <= 3'd3) || (op == 3'd6);
    endfunction

    // Monitor: every Done pulse pops one expected commit.
    always @(negedge Clk) begin
        if (Rst_n === 1'b1 && Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(Done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_hi", Hi, mon_e.hi);
                chk("done_lo", Lo, mon_e.lo);
                chk("done_result", Result, mon_e.res);
                chk("done_busy", 32'(Busy), 32'd0);
            end
        end
    end

    // Called at a negedge; leaves #1 after the accept edge.
    task automatic kick(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    // Issue an op and, for multicycle ops, wait for Done, checking latency,
    // Busy duration and optionally an ignored Start while busy.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit noise);
        bit mc;
        int lat;
        int busy_cycles;
        kick(op, a, b);
        mc = model_apply(op, a, b);
        if (mc) begin
            exp_q.push_back('{hi: m_hi, lo: m_lo, res: m_res});
            lat = -1;
            busy_cycles = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge Clk);
                if (Done === 1'b1) begin
                    lat = k;
                    break;
                end
                if (Busy === 1'b1) busy_cycles++;
                if (noise && k == 15) begin
                    Start = 1'b1;
                    Op    = 3'($urandom_range(0, 7));
                    A     = $urandom;
                    B     = $urandom;
                    #1 chk("stall_start_busy", 32'(Stall), 32'd1);
                end
                if (noise && k == 16) Start = 1'b0;
            end
            chk("done_latency", 32'(lat), 32'd34);
            chk("busy_cycles", 32'(busy_cycles), 32'd34);
        end else begin
            @(negedge Clk);
            chk("mt_hi", Hi, m_hi);
            chk("mt_lo", Lo, m_lo);
            chk("mt_busy", 32'(Busy), 32'd0);
            chk("mt_done", 32'(Done), 32'd0);
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst_n = 1'b0; Start = 1'b0; Op = '0; A = '0; B = '0; Flush = 1'b0; ReadReq = 1'b0;
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_hi", Hi, 32'd0);
        chk("rst_lo", Lo, 32'd0);
        chk("rst_result", Result, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Signed vs unsigned multiply of the same bit patterns
        issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        chk("mult_hi", Hi, 32'hFFFF_FFFF);
        chk("mult_lo", Lo, 32'hFFFF_FFFE);
        issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        chk("multu_hi", Hi, 32'h0000_0001);
        chk("multu_lo", Lo, 32'hFFFF_FFFE);

        // MADD carry across the HI/LO boundary
        issue(3'd4, 32'h0000_0000, 32'h0, 1'b0);
        issue(3'd5, 32'hFFFF_FFFF, 32'h0, 1'b0);
        issue(3'd2, 32'h0000_0001, 32'h0000_0001, 1'b0);
        chk("madd_hi", Hi, 32'h0000_0001);
        chk("madd_lo", Lo, 32'h0000_0000);

        // MSUB from zero, then MUL leaves Hi/Lo alone
        issue(3'd4, 32'h0, 32'h0, 1'b0);
        issue(3'd5, 32'h0, 32'h0, 1'b0);
        issue(3'd3, 32'd3, 32'd5, 1'b0);
        chk("msub_hi", Hi, 32'hFFFF_FFFF);
        chk("msub_lo", Lo, 32'hFFFF_FFF1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd6, 1'b0);
        chk("mul_result", Result, 32'hFFFF_FFD6);
        chk("mul_hi_kept", Hi, 32'hFFFF_FFFF);
        chk("mul_lo_kept", Lo, 32'hFFFF_FFF1);

        // Stall on ReadReq, then flush a MULT at cycle 10
        ReadReq = 1'b1;
        #1 chk("stall_idle", 32'(Stall), 32'd0);
        ReadReq = 1'b0;
        @(negedge Clk);
        kick(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int k = 0; k <= 10; k++) begin
            @(negedge Clk);
            if (k == 5) begin
                ReadReq = 1'b1;
                #1 chk("stall_readreq", 32'(Stall), 32'd1);
                ReadReq = 1'b0;
            end
        end
        Flush = 1'b1;
        @(posedge Clk);
        #1 Flush = 1'b0;
        @(negedge Clk);
        chk("flush_busy", 32'(Busy), 32'd0);
        repeat (40) @(negedge Clk);
        chk("flush_hi", Hi, m_hi);
        chk("flush_lo", Lo, m_lo);
        chk("flush_result", Result, m_res);

        // Flush beats an MTHI in IDLE
        Flush = 1'b1;
        kick(3'd4, 32'hDEAD_BEEF, 32'h0);
        Flush = 1'b0;
        @(negedge Clk);
        chk("flush_mthi_hi", Hi, m_hi);
        chk("flush_mthi_busy", 32'(Busy), 32'd0);

        // Reserved opcode is ignored
        issue(3'd7, 32'hCAFE_F00D, 32'h1111_1111, 1'b0);

        // Randomized ops, back-to-back in the Done cycle
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
                  ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset at cycle 20 of a MADD
        kick(3'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        repeat (20) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_hi", Hi, 32'd0);
        chk("arst_lo", Lo, 32'd0);
        chk("arst_result", Result, 32'd0);
        chk("arst_busy", 32'(Busy), 32'd0);
        chk("arst_done", 32'(Done), 32'd0);
        m_hi = '0; m_lo = '0; m_res = '0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(3'd6, 32'h8000_0000, 32'h8000_0000, 1'b0);

        repeat (3) @(negedge Clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_mdu_ctrl.md
HILO_MDU_CTRL -- requirements
Module: hilo_mdu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset inputs.
REQ-002 Clk  in  1  rising-edge clock for all state.
REQ-003 Rst_n  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to Clk.
REQ-004 Start  in  1  request to issue the operation on Op/A/B; accepted only in IDLE.
REQ-005 Op  in  3  operation: 000 MULT (signed), 001 MULTU, 010 MADD (signed), 011 MSUB (signed), 100 MTHI, 101 MTLO, 110 MUL (signed, low 32 bits to Result); 111 reserved, ignored.
REQ-006 A  in  32  operand rs.
REQ-007 B  in  32  operand rt.
REQ-008 Flush  in  1  synchronous pipeline flush; abandons any in-flight operation.
REQ-009 ReadReq  in  1  pipeline is issuing mfhi/mflo this cycle.
REQ-010 Busy  out  1  high whenever state is not IDLE.
REQ-011 Stall  out  1  combinational ReadReq & Busy, or Start & Busy.
REQ-012 Done  out  1  registered one-cycle pulse on completion of a multicycle operation.
REQ-013 Result  out  32  low 32 bits of the last completed MUL; held until the next MUL completes.
REQ-014 Hi  out  32  architectural HI register.
REQ-015 Lo  out  32  architectural LO register.

Function
REQ-016 States SHALL be IDLE, ITER, FIX, WRITE, encoded in 2 bits.
REQ-017 IDLE, Start=1, Flush=0, Op in {000,001,010,011,110} SHALL latch the operand magnitudes (absolute values for signed ops, raw values for MULTU), the product sign A[31]^B[31] (0 for MULTU) and Op; clear the 64-bit product and the 6-bit counter; go to ITER.
REQ-018 IDLE, Start=1, Flush=0, Op=100 (101) SHALL write A into Hi (Lo) at that edge, stay in IDLE, leave Busy low and not pulse Done.
REQ-019 IDLE, Start=1, Op=111 SHALL be ignored, with no state change.
REQ-020 ITER SHALL perform one radix-2 shift-add step per cycle for exactly 32 cycles, then go to FIX.
REQ-021 FIX SHALL two's-complement negate the 64-bit product when the sign bit is 1, then go to WRITE.
REQ-022 WRITE SHALL update state according to the latched Op, then return to IDLE:
- MULT/MULTU: {Hi,Lo} = product.
- MADD: {Hi,Lo} = {Hi,Lo} + product, modulo 2^64.
- MSUB: {Hi,Lo} = {Hi,Lo} - product, modulo 2^64.
- MUL: Result = product[31:0]; Hi and Lo unchanged.
REQ-023 Done SHALL be high for exactly the one cycle after the WRITE edge.
REQ-024 Latency: Start is accepted at edge 0; the result is visible after edge 34; Done is high during cycle 34-35; Busy is high from edge 0 to edge 34.
REQ-025 Start while Busy SHALL be ignored; the requester holds Start while Stall=1.
REQ-026 Flush=1 in any state SHALL return the block to IDLE at the next edge, with no write to Hi, Lo or Result and no Done pulse.
REQ-027 Flush=1 together with Start=1 in IDLE SHALL win: nothing is accepted, including MTHI/MTLO.
REQ-028 Start in the cycle Done is high (state IDLE) SHALL be accepted normally.
REQ-029 Hi and Lo SHALL change only at a WRITE edge or at an MTHI/MTLO accept edge.

Reset
REQ-030 While Rst_n=0: state=IDLE, Busy=0, Done=0, Hi=0, Lo=0, Result=0, and all internal product, operand and counter registers cleared.
REQ-031 Reset asserted mid-operation SHALL abort the operation, with all outputs at their reset values.

Verification
REQ-032 MULT A=0xFFFFFFFF, B=0x00000002 -> after 34 edges Hi=0xFFFFFFFF, Lo=0xFFFFFFFE; Done pulses once; Busy high for 34 cycles.
REQ-033 MULTU A=0xFFFFFFFF, B=0x00000002 -> Hi=0x00000001, Lo=0xFFFFFFFE.
REQ-034 MTLO A=0xFFFFFFFF, then MADD A=1, B=1 -> Hi=0x00000001, Lo=0x00000000 (carry propagates across the HI/LO boundary).
REQ-035 Hi=Lo=0, MSUB A=3, B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; a MUL A=-7, B=6 issued afterwards -> Result=0xFFFFFFD6 and Hi/Lo unchanged.
REQ-036 ReadReq=1 during ITER -> Stall=1. Flush at cycle 10 of a MULT -> Busy=0 next cycle, no Done, Hi/Lo unchanged.
REQ-037 Rst_n low at cycle 20 of a MADD -> Hi=Lo=Result=0 and Busy=0 immediately.
